// File: rtl/baud_pkg.sv
// baud_pkg: shared widths and 50 MHz / 16x divisor presets for the fractional baud generator
package baud_pkg;
  localparam int BAUD_DIV_W = 16;
  localparam int BAUD_FRAC_W = 4;
  localparam int BAUD_OSR = 16;
  localparam int BAUD_9600_DIV = 325;
  localparam int BAUD_9600_FRAC = 8;
  localparam int BAUD_115200_DIV = 27;
  localparam int BAUD_115200_FRAC = 2;
endpackage

// File: rtl/baud_osr_counter.sv
// baud_osr_counter: tick index within a bit, with bit-boundary and mid-bit strobes
module baud_osr_counter
  import baud_pkg::*;
#(
  parameter int OSR = BAUD_OSR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   resync,
  input  logic                   tick,
  output logic [$clog2(OSR)-1:0] osr_cnt,
  output logic                   bit_tick,
  output logic                   mid_tick
);
  localparam int OSR_W = $clog2(OSR);
  logic [OSR_W-1:0] osr_d, osr_q;
  logic adv;
  always_comb begin
    adv = tick && en && !resync;
    osr_d = resync ? '0 : adv ? osr_q + OSR_W'(1) : osr_q;
    bit_tick = adv && osr_q == OSR_W'(OSR - 1);
    mid_tick = adv && osr_q == OSR_W'(OSR / 2 - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) osr_q <= '0;
    else osr_q <= osr_d;
  end
  assign osr_cnt = osr_q;
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional UART baud generator with shadowed divisor and phase resync
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W = BAUD_DIV_W,
  parameter int FRAC_W = BAUD_FRAC_W,
  parameter int OSR = BAUD_OSR,
  parameter int DEF_DIV = BAUD_9600_DIV,
  parameter int DEF_FRAC = BAUD_9600_FRAC
) (
  input  logic                   clk_50MHz,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   resync,
  input  logic                   cfg_we,
  input  logic [DIV_W-1:0]       cfg_div,
  input  logic [FRAC_W-1:0]      cfg_frac,
  output logic                   cfg_pending,
  output logic                   cfg_err,
  output logic                   tick,
  output logic                   bit_tick,
  output logic                   mid_tick,
  output logic [$clog2(OSR)-1:0] osr_cnt
);
  logic [DIV_W:0] cnt_d, cnt_q, last_cnt;
  logic [FRAC_W-1:0] acc_d, acc_q, frac_a_d, frac_a_q, frac_s_d, frac_s_q;
  logic [DIV_W-1:0] div_a_d, div_a_q, div_s_d, div_s_q;
  logic [FRAC_W:0] acc_sum;
  logic extra_d, extra_q, pend_d, pend_q, err_d, err_q, cfg_ok, apply;
  // Period is div_a + extra, so the last count is div_a - 1 unless lengthened.
  always_comb begin
    last_cnt = {1'b0, div_a_q} - (DIV_W + 1)'(!extra_q);
    tick = en && !resync && !reset && cnt_q == last_cnt;
    acc_sum = {1'b0, acc_q} + {1'b0, frac_a_q};
    cfg_ok = cfg_we && cfg_div >= DIV_W'(2);
    apply = pend_q && (tick || resync);
    cnt_d = (resync || tick) ? '0 : en ? cnt_q + (DIV_W + 1)'(1) : cnt_q;
    acc_d = resync ? '0 : tick ? acc_sum[FRAC_W-1:0] : acc_q;
    extra_d = resync ? 1'b0 : tick ? acc_sum[FRAC_W] : extra_q;
    div_a_d = apply ? div_s_q : div_a_q;
    frac_a_d = apply ? frac_s_q : frac_a_q;
    div_s_d = cfg_ok ? cfg_div : div_s_q;
    frac_s_d = cfg_ok ? cfg_frac : frac_s_q;
    pend_d = cfg_ok || (pend_q && !apply);
    err_d = cfg_we && !cfg_ok;
  end
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      extra_q <= 1'b0;
      div_a_q <= DIV_W'(DEF_DIV);
      frac_a_q <= FRAC_W'(DEF_FRAC);
      div_s_q <= DIV_W'(DEF_DIV);
      frac_s_q <= FRAC_W'(DEF_FRAC);
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      extra_q <= extra_d;
      div_a_q <= div_a_d;
      frac_a_q <= frac_a_d;
      div_s_q <= div_s_d;
      frac_s_q <= frac_s_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign cfg_pending = pend_q;
  assign cfg_err = err_q;
  baud_osr_counter #(.OSR(OSR)) u_osr (
    .clk(clk_50MHz),
    .rst(reset),
    .en(en),
    .resync(resync),
    .tick(tick),
    .osr_cnt(osr_cnt),
    .bit_tick(bit_tick),
    .mid_tick(mid_tick)
  );
endmodule
